axil_master_arb: RTL and testbench

AXIL_MASTER_ARB -- requirements
Module: axil_master_arb

---
 rtl/axil_arb_pkg.sv | 8 +
 rtl/rr_arb2.sv | 15 +
 rtl/axil_master_arb.sv | 116 +++++++++++
 tb/tb_axil_master_arb.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/axil_arb_pkg.sv
// axil_arb_pkg: shared FSM states, AXI response codes and requester count for the arbiter
package axil_arb_pkg;
  localparam int NUM_REQ = 2;
  localparam logic [1:0] OKAY = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant; the requester not granted last wins a tie
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);
  logic last;
  always_comb grant = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
  // last starts at 1 so requester 0 wins the first tie after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (accept && |grant) last <= grant[1];
endmodule

// File: rtl/axil_master_arb.sv
// axil_master_arb: two requesters share one AXI4-Lite master port, one transaction at a time
module axil_master_arb
  import axil_arb_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [2*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [2*C_M_AXI_DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  state_t          state;
  logic            sel;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            awv, wv, arv;
  logic [1:0]      gnt;
  logic            accept;
  logic            aw_pend, w_pend;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  assign accept = (state == IDLE) && |req_valid;
  rr_arb2 u_arb (.clk(ACLK), .rst_n(ARESETN), .req(req_valid), .accept(accept), .grant(gnt));
  assign sel_we    = gnt[1] ? req_we[1] : req_we[0];
  assign sel_addr  = gnt[1] ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
  assign sel_wdata = gnt[1] ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
  assign req_ready = accept ? gnt : '0;
  assign rsp_valid = (state == DONE) ? (sel ? 2'b10 : 2'b01) : 2'b00;
  // each write channel drops on its own handshake; WR ends once neither is pending
  assign aw_pend = awv && !M_AXI_AWREADY;
  assign w_pend  = wv && !M_AXI_WREADY;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWVALID = awv;
  assign M_AXI_WVALID  = wv;
  assign M_AXI_ARVALID = arv;
  assign M_AXI_BREADY  = (state == WR_RESP);
  assign M_AXI_RREADY  = (state == RD_DATA);
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state     <= IDLE;
      sel       <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      awv       <= 1'b0;
      wv        <= 1'b0;
      arv       <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= OKAY;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sel     <= gnt[1];
          addr_q  <= sel_addr;
          wdata_q <= sel_wdata;
          awv     <= sel_we;
          wv      <= sel_we;
          arv     <= !sel_we;
          state   <= sel_we ? WR : RD_ADDR;
        end
        WR: begin
          awv <= aw_pend;
          wv  <= w_pend;
          if (!aw_pend && !w_pend) state <= WR_RESP;
        end
        WR_RESP: if (M_AXI_BVALID) begin
          rsp_resp  <= M_AXI_BRESP;
          rsp_rdata <= '0;
          state     <= DONE;
        end
        RD_ADDR: if (M_AXI_ARREADY) begin
          arv   <= 1'b0;
          state <= RD_DATA;
        end
        RD_DATA: if (M_AXI_RVALID) begin
          rsp_rdata <= M_AXI_RDATA;
          rsp_resp  <= M_AXI_RRESP;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_axil_master_arb.sv
// tb_axil_master_arb: directed tests of the arbiter against a small 4-register AXI4-Lite slave
module tb_axil_master_arb;
  import axil_arb_pkg::*;
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_resp;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] rsp_rdata;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BREADY;
  logic M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;

  axil_master_arb dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  // slave: 4 registers, programmable AWREADY/WREADY delays, optional BRESP and B stall
  logic [31:0] mem [4];
  logic        aw_got, w_got, b_hold;
  logic [31:0] aw_a, w_d;
  logic [1:0]  bresp_cfg;
  int aw_cnt, w_cnt, aw_hs, w_hs, aw_dly, w_dly;
  assign M_AXI_AWREADY = M_AXI_AWVALID && !aw_got && (aw_cnt >= aw_dly);
  assign M_AXI_WREADY  = M_AXI_WVALID && !w_got && (w_cnt >= w_dly);
  assign M_AXI_ARREADY = M_AXI_ARVALID && !M_AXI_RVALID;
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0; aw_hs <= 0; w_hs <= 0;
      aw_a <= '0; w_d <= '0; M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'd0;
      M_AXI_RVALID <= 1'b0; M_AXI_RDATA <= '0; M_AXI_RRESP <= 2'd0;
    end else begin
      if (M_AXI_AWVALID && !aw_got) begin
        if (M_AXI_AWREADY) begin aw_got <= 1'b1; aw_a <= M_AXI_AWADDR; aw_hs <= aw_hs + 1; end
        else aw_cnt <= aw_cnt + 1;
      end
      if (M_AXI_WVALID && !w_got) begin
        if (M_AXI_WREADY) begin w_got <= 1'b1; w_d <= M_AXI_WDATA; w_hs <= w_hs + 1; end
        else w_cnt <= w_cnt + 1;
      end
      if (aw_got && w_got && !M_AXI_BVALID && !b_hold) begin
        M_AXI_BVALID <= 1'b1; M_AXI_BRESP <= bresp_cfg; mem[aw_a[3:2]] <= w_d;
        aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
      end else if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        M_AXI_RVALID <= 1'b1;
        M_AXI_RDATA  <= mem[M_AXI_ARADDR[3:2]];
        M_AXI_RRESP  <= (M_AXI_ARADDR[3:0] == 4'hC) ? SLVERR : OKAY;
      end else if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
    end

  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} cmd_t;
  cmd_t q0[$], q1[$];
  int g_who[$], g_cyc[$], r_who[$], r_cyc[$];
  logic [31:0] r_data[$];
  logic [1:0]  r_resp[$];
  int cyc_n, n_aw_only, n_w_only, errors, checks, a0, w0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refill();
    req_valid[0] = q0.size() > 0;
    req_valid[1] = q1.size() > 0;
    if (q0.size() > 0) begin req_we[0] = q0[0].we; req_addr[31:0] = q0[0].addr; req_wdata[31:0] = q0[0].data; end
    if (q1.size() > 0) begin req_we[1] = q1[0].we; req_addr[63:32] = q1[0].addr; req_wdata[63:32] = q1[0].data; end
  endtask

  task automatic clear_logs();
    g_who.delete(); g_cyc.delete(); r_who.delete(); r_cyc.delete(); r_data.delete(); r_resp.delete();
    n_aw_only = 0; n_w_only = 0;
  endtask

  // one clock: sample on the falling edge, update requesters just after the rising edge
  task automatic cyc();
    logic [1:0] rdy;
    @(negedge ACLK);
    cyc_n++;
    rdy = req_ready;
    if (rdy[0]) begin g_who.push_back(0); g_cyc.push_back(cyc_n); end
    if (rdy[1]) begin g_who.push_back(1); g_cyc.push_back(cyc_n); end
    if (|rsp_valid) begin
      r_who.push_back(rsp_valid == 2'b01 ? 0 : rsp_valid == 2'b10 ? 1 : 3);
      r_cyc.push_back(cyc_n); r_data.push_back(rsp_rdata); r_resp.push_back(rsp_resp);
    end
    if (M_AXI_AWVALID && !M_AXI_WVALID) n_aw_only++;
    if (M_AXI_WVALID && !M_AXI_AWVALID) n_w_only++;
    @(posedge ACLK);
    #1;
    if (rdy[0]) void'(q0.pop_front());
    if (rdy[1]) void'(q1.pop_front());
    refill();
  endtask

  task automatic run(input int n, input int budget);
    for (int i = 0; i < budget && r_who.size() < n; i++) cyc();
    chk("rsp_count", r_who.size(), n);
  endtask

  initial begin
    int exp_g[5], exp_d[5];
    errors = 0; checks = 0; cyc_n = 0;
    aw_dly = 0; w_dly = 0; b_hold = 1'b0; bresp_cfg = OKAY;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    clear_logs();
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 0);
    chk("rst_rsp", {rsp_valid, rsp_resp, req_ready}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    ARESETN = 1'b1;
    // write then read back through requester 0; write latency is 4 cycles with a zero-wait slave
    q0.push_back('{1'b1, 32'h0, 32'h1});
    q0.push_back('{1'b0, 32'h0, 32'h0});
    refill();
    run(2, 100);
    chk("t1_wr_who", r_who[0], 0);
    chk("t1_wr_rdata", r_data[0], 0);
    chk("t1_wr_resp", r_resp[0], 0);
    chk("t1_wr_latency", r_cyc[0] - g_cyc[0], 4);
    chk("t1_rd_who", r_who[1], 0);
    chk("t1_rd_rdata", r_data[1], 32'h1);
    chk("t1_rd_resp", r_resp[1], 0);
    // fresh reset so requester 0 owns the first tie
    ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    clear_logs();
    q0.push_back('{1'b1, 32'h4, 32'h2});
    q1.push_back('{1'b0, 32'h4, 32'h0});
    refill();
    run(2, 100);
    chk("t2_grant0", g_who[0], 0);
    chk("t2_grant1", g_who[1], 1);
    chk("t2_rsp1_who", r_who[1], 1);
    chk("t2_rsp1_rdata", r_data[1], 32'h2);
    chk("t2_rsp1_resp", r_resp[1], 0);
    // requester 0 streams three commands while requester 1 stays valid
    clear_logs();
    q0.push_back('{1'b1, 32'h8, 32'h33});
    q0.push_back('{1'b0, 32'h8, 32'h0});
    q0.push_back('{1'b1, 32'h0, 32'h55});
    q1.push_back('{1'b0, 32'h0, 32'h0});
    q1.push_back('{1'b0, 32'h4, 32'h0});
    refill();
    run(5, 300);
    exp_g = '{0, 1, 0, 1, 0};
    exp_d = '{0, 1, 'h33, 2, 0};
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_grant%0d", i), g_who[i], exp_g[i]);
      chk($sformatf("t3_rsp_who%0d", i), r_who[i], exp_g[i]);
      chk($sformatf("t3_rdata%0d", i), r_data[i], exp_d[i]);
    end
    // WREADY lags AWREADY
    clear_logs();
    a0 = aw_hs; w0 = w_hs; w_dly = 5;
    q0.push_back('{1'b1, 32'h4, 32'h77});
    refill();
    run(1, 100);
    chk("t4a_resp", r_resp[0], OKAY);
    chk("t4a_aw_hs", aw_hs - a0, 1);
    chk("t4a_w_hs", w_hs - w0, 1);
    chk("t4a_aw_drop_first", n_w_only > 0, 1);
    chk("t4a_no_w_drop_first", n_aw_only, 0);
    // AWREADY lags WREADY, slave reports SLVERR
    clear_logs();
    a0 = aw_hs; w0 = w_hs; w_dly = 0; aw_dly = 5; bresp_cfg = SLVERR;
    q1.push_back('{1'b1, 32'h8, 32'h88});
    refill();
    run(1, 100);
    chk("t4b_who", r_who[0], 1);
    chk("t4b_resp", r_resp[0], SLVERR);
    chk("t4b_aw_hs", aw_hs - a0, 1);
    chk("t4b_w_hs", w_hs - w0, 1);
    chk("t4b_w_drop_first", n_aw_only > 0, 1);
    chk("t4b_no_aw_drop_first", n_w_only, 0);
    aw_dly = 0; bresp_cfg = OKAY;
    // reset while waiting for B
    clear_logs();
    b_hold = 1'b1;
    q0.push_back('{1'b1, 32'h8, 32'h99});
    refill();
    for (int i = 0; i < 50 && !M_AXI_BREADY; i++) cyc();
    chk("t5_in_wr_resp", M_AXI_BREADY, 1);
    ARESETN = 1'b0;
    #1;
    chk("t5_valids_cleared", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 0);
    chk("t5_rsp_cleared", {rsp_valid, rsp_resp}, 0);
    q0.delete();
    refill();
    b_hold = 1'b0;
    repeat (3) cyc();
    chk("t5_no_rsp", r_who.size(), 0);
    ARESETN = 1'b1;
    q0.push_back('{1'b1, 32'h8, 32'hA5});
    q0.push_back('{1'b0, 32'h8, 32'h0});
    refill();
    run(2, 100);
    chk("t5_wr_resp", r_resp[0], OKAY);
    chk("t5_rd_rdata", r_data[1], 32'hA5);
    // SLVERR read, then the FSM grants again the cycle after DONE
    clear_logs();
    q0.push_back('{1'b0, 32'hC, 32'h0});
    q0.push_back('{1'b0, 32'h8, 32'h0});
    refill();
    run(2, 100);
    chk("t6_err_resp", r_resp[0], SLVERR);
    chk("t6_next_grant_cycle", g_cyc[1], r_cyc[0] + 1);
    chk("t6_next_resp", r_resp[1], OKAY);
    chk("t6_next_rdata", r_data[1], 32'hA5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
